mpi_link_rx_endpoint: RTL and testbench
=======================================

// Module: mpi_link_rx_endpoint
// PURPOSE
//  Receiving end of the credit-based (valid/data + yummy) link carried between MPI ranks.
//  - Accepts one flit per cycle from the MPI exchange shim.
//  - Buffers flits in a DEPTH-entry FIFO and presents them to the local consumer with valid/ready.
//  - Returns one yummy (credit) to the sending rank for every flit consumed.
//  - Sits on rank 0, between the per-cycle MPI receive shim and the local NoC/router port.
// PARAMETERS
//  DATA_W  64  flit width in bits
//  DEPTH   4   FIFO entries; power of 2, >=2; equals the initial credit count held by the remote sender
//  CNT_W   $clog2(DEPTH+1)  localparam, occupancy counter width (not overridable)
// PORTS
//  clk_i           in   1       clock; all state updates on posedge
//  rst_i           in   1       asynchronous reset, active-high
//  link_valid_i    in   1       flit present from remote rank this cycle
//  link_data_i     in   DATA_W  flit payload, sampled when link_valid_i=1
//  link_yummy_o    out  1       one-cycle credit-return pulse to remote rank
//  out_valid_o     out  1       head flit available to local consumer
//  out_data_o      out  DATA_W  head flit payload
//  out_ready_i     in   1       consumer accepts; pop when out_valid_o & out_ready_i
//  count_o         out  CNT_W   current FIFO occupancy, 0..DEPTH
//  err_overflow_o  out  1       sticky: flit arrived with no free entry
// BEHAVIOUR
//  - Reset (async assert, sync-safe deassert):
//    - rd/wr pointers and count cleared to 0.
//    - Stored flits discarded; any pending yummy is dropped.
//    - link_yummy_o=0, out_valid_o=0, out_data_o=0, count_o=0, err_overflow_o=0.
//  - Storage: circular buffer, rd_ptr/wr_ptr of $clog2(DEPTH) bits, wrap from DEPTH-1 to 0.
//    - count is tracked separately, so full (count==DEPTH) is distinct from empty (count==0).
//  - Push: link_valid_i=1 and (count<DEPTH, or a pop occurs in the same cycle).
//    - Entry written at wr_ptr; wr_ptr++.
//  - Pop: out_valid_o & out_ready_i; rd_ptr++.
//  - out_valid_o = (count!=0); out_data_o = mem[rd_ptr]. Both are registered state.
//    - Latency: flit pushed at edge N is visible from edge N (after the write) -> consumable in cycle N+1.
//  - count update: push & !pop -> +1; pop & !push -> -1; both or neither -> unchanged.
//  - Push and pop in the same cycle while full: both succeed, count stays DEPTH, no error.
//  - Push and pop in the same cycle while count==1: old head popped, new flit becomes head next cycle.
//  - Overflow: link_valid_i=1 while count==DEPTH with no pop.
//    - Flit dropped; state unchanged; err_overflow_o set to 1 and held until reset.
//  - Yummy: link_yummy_o registered, =1 in the cycle after each pop, else 0.
//    - At most one pulse per cycle; exactly one pulse per consumed flit; none at reset.
//  - out_ready_i while out_valid_o=0 is ignored (no pop, no yummy).
//  - Ordering is strictly FIFO. No flit is duplicated or reordered across pointer wrap.
// CONFIGURATION
//  MPI_LINK_RX_BYPASS_EN
//  - Defined: when count==0, link_valid_i=1 and out_ready_i=1, the flit passes combinationally.
//    - out_valid_o=1 and out_data_o=link_data_i in the same cycle.
//    - The flit is not stored, count stays 0, and link_yummy_o pulses next cycle.
//    - out_valid_o is then combinationally dependent on link_valid_i and out_ready_i.
//  - Undefined: no combinational path; outputs come purely from FIFO state; minimum latency 1 cycle.
// TESTING  (DEPTH=4, DATA_W=64)
//  1 Reset: assert rst_i with count=3 and a yummy pending -> same cycle all outputs 0; no yummy after release.
//  2 Single flit: push 64'hDEAD_BEEF_0000_0001 with ready=0 -> next cycle out_valid_o=1, data matches, count_o=1;
//    raise ready 1 cycle -> count_o=0, link_yummy_o=1 for exactly 1 cycle.
//  3 Overflow: push 0x1..0x4 with ready=0 -> count_o=4; push 0x5 -> dropped, err_overflow_o=1 and held;
//    drain -> 0x1,0x2,0x3,0x4 then 4 yummies.
//  4 Full + simultaneous: count=4, push 0xA while popping -> count_o stays 4, err stays 0, order preserved, 1 yummy.
//  5 Wrap: stream 10 flits 0x10..0x19 with ready=1 throughout -> all delivered in order, 10 yummies, err=0.
//  6 Bypass: empty FIFO, push 0x77 with ready=1 -> with MPI_LINK_RX_BYPASS_EN: out_valid_o=1 same cycle, count_o=0;
//    without: out_valid_o=1 next cycle; in both cases one yummy.

Source files
------------

// File: rtl/mpi_link_rx_endpoint.sv
`default_nettype none
// ============================================================================
// Module      : mpi_link_rx_endpoint
// Description : Receive side of the credit-based (valid/data + yummy) link
//               between MPI ranks. Incoming flits are buffered in a DEPTH-entry
//               circular FIFO and handed to the local consumer with
//               valid/ready. Every consumed flit returns one yummy (credit)
//               to the remote sender.
//               Optional feature macro: MPI_LINK_RX_BYPASS_EN
//                 defined   -> an empty FIFO with a ready consumer forwards
//                              the incoming flit combinationally.
//                 undefined -> outputs come purely from FIFO state.
// Revision    : 1.0 - initial release
// ============================================================================
module mpi_link_rx_endpoint #(
  parameter int  DATA_W = 64,
  parameter int  DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              link_valid_i,
  input  logic [DATA_W-1:0] link_data_i,
  output logic              link_yummy_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic [CNT_W-1:0]  count_o,
  output logic              err_overflow_o
);

  localparam int               c_ptr_w   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] c_full    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_yummy;
  logic               r_err;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_consumed;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_full);
  // A pop only happens when the FIFO really holds a flit; ready on an empty
  // FIFO is ignored.
  assign w_pop   = ~w_empty & out_ready_i;

`ifdef MPI_LINK_RX_BYPASS_EN
  logic w_bypass;

  // Empty FIFO with a ready consumer: the flit is forwarded, never stored.
  assign w_bypass    = w_empty & link_valid_i & out_ready_i;
  assign w_push      = link_valid_i & ~w_bypass & (~w_full | w_pop);
  assign w_consumed  = w_pop | w_bypass;
  assign out_valid_o = ~w_empty | w_bypass;
  assign out_data_o  = w_bypass ? link_data_i : r_mem[r_rd_ptr];
`else
  // Push is allowed when space exists or the head leaves in the same cycle.
  assign w_push      = link_valid_i & (~w_full | w_pop);
  assign w_consumed  = w_pop;
  assign out_valid_o = ~w_empty;
  assign out_data_o  = r_mem[r_rd_ptr];
`endif

  assign count_o        = r_count;
  assign link_yummy_o   = r_yummy;
  assign err_overflow_o = r_err;

  // Flit storage; cleared on reset so the head payload reads zero afterwards.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= link_data_i;
    end
  end

  // Read/write pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
    end
  end

  // Occupancy is kept separately so full and empty are distinguishable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (w_push && !w_pop) begin
      r_count <= r_count + c_cnt_one;
    end else if (w_pop && !w_push) begin
      r_count <= r_count - c_cnt_one;
    end
  end

  // One credit pulse in the cycle following each consumed flit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_yummy <= 1'b0;
    end else begin
      r_yummy <= w_consumed;
    end
  end

  // Sticky overflow flag: a flit arrived with no room and no concurrent pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (link_valid_i && w_full && !w_pop) begin
      r_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mpi_link_rx_endpoint.sv
`default_nettype none
// ============================================================================
// Module      : tb_mpi_link_rx_endpoint
// Description : Scoreboard bench for mpi_link_rx_endpoint (DEPTH=4, DATA_W=64).
//               Stimulus queues expected flits; a negedge monitor pops and
//               compares on each consumer handshake and counts yummy pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mpi_link_rx_endpoint;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              link_valid = 1'b0;
  logic [DATA_W-1:0] link_data = '0;
  logic              link_yummy;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready = 1'b0;
  logic [CNT_W-1:0]  count;
  logic              err;

  mpi_link_rx_endpoint #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .link_valid_i   (link_valid),
    .link_data_i    (link_data),
    .link_yummy_o   (link_yummy),
    .out_valid_o    (out_valid),
    .out_data_o     (out_data),
    .out_ready_i    (out_ready),
    .count_o        (count),
    .err_overflow_o (err)
  );

  always #5 clk = ~clk;

  // Expected flit order for the consumer side.
  logic [63:0] exp_q [$];
  // Direct checks posted by the stimulus, evaluated by the monitor.
  string       cn_q [$];
  logic [63:0] ca_q [$];
  logic [63:0] ce_q [$];

  int checks = 0;
  int errors = 0;
  int yummy_seen = 0;

  string       m_name;
  logic [63:0] m_act;
  logic [63:0] m_exp;

  // Monitor: sole owner of the check/error counters.
  always @(negedge clk) begin
    while (cn_q.size() > 0) begin
      m_name = cn_q.pop_front();
      m_act  = ca_q.pop_front();
      m_exp  = ce_q.pop_front();
      checks++;
      if (m_act !== m_exp) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", m_name, m_act, m_exp);
      end
    end
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %0h expected no flit", out_data);
      end else begin
        m_exp = exp_q.pop_front();
        if (out_data !== m_exp) begin
          errors++;
          $display("FAIL pop_data: got %0h expected %0h", out_data, m_exp);
        end
      end
    end
    if (!rst && link_yummy) begin
      yummy_seen++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic post(input string name, input logic [63:0] act, input logic [63:0] exp);
    cn_q.push_back(name);
    ca_q.push_back(act);
    ce_q.push_back(exp);
  endtask

  task automatic drain();
    int k;
    k = 0;
    out_ready = 1'b1;
    while (count != '0 && k < 40) begin
      step(1);
      k++;
    end
    post("drain_done", 64'(count), 64'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int y0;

    // ---- 1: reset with occupancy 3 and a yummy pending ----
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    post("rst_count", 64'(count), 64'd0);
    post("rst_valid", 64'(out_valid), 64'd0);
    post("rst_data", out_data, 64'd0);
    post("rst_yummy", 64'(link_yummy), 64'd0);
    post("rst_err", 64'(err), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      link_valid = 1'b1;
      link_data  = 64'hA0 + 64'(i);
      if (i == 1) exp_q.push_back(link_data);
      step(1);
    end
    link_valid = 1'b0;
    post("t1_count_full", 64'(count), 64'd4);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    post("t1_count3", 64'(count), 64'd3);
    post("t1_yummy_pending", 64'(link_yummy), 64'd1);
    rst = 1'b1;
    #1;
    post("t1_async_yummy", 64'(link_yummy), 64'd0);
    post("t1_async_valid", 64'(out_valid), 64'd0);
    post("t1_async_data", out_data, 64'd0);
    post("t1_async_count", 64'(count), 64'd0);
    post("t1_async_err", 64'(err), 64'd0);
    step(1);
    y0 = yummy_seen;
    rst = 1'b0;
    step(3);
    post("t1_no_yummy_after", 64'(yummy_seen - y0), 64'd0);

    // ---- 2: single flit ----
    link_valid = 1'b1;
    link_data  = 64'hDEAD_BEEF_0000_0001;
    exp_q.push_back(link_data);
    step(1);
    link_valid = 1'b0;
    post("t2_valid", 64'(out_valid), 64'd1);
    post("t2_count", 64'(count), 64'd1);
    y0 = yummy_seen;
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    post("t2_count_after", 64'(count), 64'd0);
    post("t2_yummy_hi", 64'(link_yummy), 64'd1);
    step(1);
    post("t2_yummy_lo", 64'(link_yummy), 64'd0);
    post("t2_yummy_cnt", 64'(yummy_seen - y0), 64'd1);

    // ---- 3: overflow ----
    for (int i = 1; i <= 4; i++) begin
      link_valid = 1'b1;
      link_data  = 64'(i);
      exp_q.push_back(link_data);
      step(1);
    end
    link_valid = 1'b0;
    post("t3_count_full", 64'(count), 64'd4);
    post("t3_err_before", 64'(err), 64'd0);
    link_valid = 1'b1;
    link_data  = 64'h5;
    step(1);
    link_valid = 1'b0;
    post("t3_err_set", 64'(err), 64'd1);
    post("t3_count_kept", 64'(count), 64'd4);
    y0 = yummy_seen;
    drain();
    step(2);
    post("t3_yummy_cnt", 64'(yummy_seen - y0), 64'd4);
    post("t3_err_held", 64'(err), 64'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    post("t3_err_cleared", 64'(err), 64'd0);

    // ---- 4: push and pop together while full ----
    for (int i = 1; i <= 4; i++) begin
      link_valid = 1'b1;
      link_data  = 64'hB0 + 64'(i);
      exp_q.push_back(link_data);
      step(1);
    end
    link_valid = 1'b0;
    y0 = yummy_seen;
    link_valid = 1'b1;
    link_data  = 64'hA;
    exp_q.push_back(link_data);
    out_ready  = 1'b1;
    step(1);
    link_valid = 1'b0;
    out_ready  = 1'b0;
    post("t4_count", 64'(count), 64'd4);
    post("t4_err", 64'(err), 64'd0);
    step(1);
    post("t4_yummy_cnt", 64'(yummy_seen - y0), 64'd1);
    drain();
    step(1);

    // ---- 5: stream across pointer wrap ----
    y0 = yummy_seen;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      link_valid = 1'b1;
      link_data  = 64'h10 + 64'(i);
      exp_q.push_back(link_data);
      step(1);
    end
    link_valid = 1'b0;
    drain();
    step(2);
    post("t5_yummy_cnt", 64'(yummy_seen - y0), 64'd10);
    post("t5_err", 64'(err), 64'd0);

    // ---- 6: empty FIFO with ready consumer ----
    y0 = yummy_seen;
    out_ready  = 1'b1;
    link_valid = 1'b1;
    link_data  = 64'h77;
    exp_q.push_back(link_data);
    #1;
`ifdef MPI_LINK_RX_BYPASS_EN
    post("t6_bypass_valid", 64'(out_valid), 64'd1);
    post("t6_bypass_count", 64'(count), 64'd0);
    post("t6_bypass_data", out_data, 64'h77);
    step(1);
    link_valid = 1'b0;
    step(2);
    out_ready = 1'b0;
`else
    post("t6_same_cycle_valid", 64'(out_valid), 64'd0);
    step(1);
    link_valid = 1'b0;
    post("t6_next_valid", 64'(out_valid), 64'd1);
    post("t6_next_count", 64'(count), 64'd1);
    step(2);
    out_ready = 1'b0;
`endif
    post("t6_count_end", 64'(count), 64'd0);
    post("t6_yummy_cnt", 64'(yummy_seen - y0), 64'd1);

    step(3);
    post("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    step(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
